// File: rtl/pipelined_shifter.sv
// Two-stage pipelined barrel shifter: SLL, SRL, SRA, ROR.
// Low shift bits applied in stage 1, high bits in stage 2.
module pipelined_shifter #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHIFT_WIDTH = 5,
    parameter int SPLIT       = 3,
    parameter int TAG_WIDTH   = 5
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [SHIFT_WIDTH-1:0] in_shamt,
    input  logic [1:0]             in_op,
    input  logic [TAG_WIDTH-1:0]   in_tag,
    input  logic                   flush,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_WIDTH-1:0]  out_data,
    output logic [TAG_WIDTH-1:0]   out_tag
);

    localparam int HI_W = SHIFT_WIDTH - SPLIT;

    if (DATA_WIDTH != (1 << SHIFT_WIDTH)) begin : g_bad_width
        $error("pipelined_shifter: DATA_WIDTH must be 2**SHIFT_WIDTH");
    end
    if (SPLIT < 1 || SPLIT >= SHIFT_WIDTH) begin : g_bad_split
        $error("pipelined_shifter: SPLIT out of range");
    end

    // One partial shift; fill is the operand's original msb for SRA.
    function automatic logic [DATA_WIDTH-1:0] f_shift(
        input logic [DATA_WIDTH-1:0]  d,
        input logic [SHIFT_WIDTH-1:0] amt,
        input logic [1:0]             op,
        input logic                   fill
    );
        logic [2*DATA_WIDTH-1:0] dbl;
        logic [DATA_WIDTH-1:0]   res;
        dbl = '0;
        res = '0;
        case (op)
            2'b00: res = d << amt;
            2'b01: res = d >> amt;
            2'b10: begin
                dbl = {{DATA_WIDTH{fill}}, d} >> amt;
                res = dbl[DATA_WIDTH-1:0];
            end
            default: begin
                dbl = {d, d} >> amt;
                res = dbl[DATA_WIDTH-1:0];
            end
        endcase
        return res;
    endfunction

    logic                   r_s1_valid;
    logic [DATA_WIDTH-1:0]  r_s1_data;
    logic [HI_W-1:0]        r_s1_shhi;
    logic [1:0]             r_s1_op;
    logic [TAG_WIDTH-1:0]   r_s1_tag;
    logic                   r_s1_msb;

    logic                   r_out_valid;
    logic [DATA_WIDTH-1:0]  r_out_data;
    logic [TAG_WIDTH-1:0]   r_out_tag;

    logic                   w_s2_load;
    logic                   w_in_fire;
    logic [SHIFT_WIDTH-1:0] w_s1_amt;
    logic [SHIFT_WIDTH-1:0] w_s2_amt;
    logic [DATA_WIDTH-1:0]  w_s1_res;
    logic [DATA_WIDTH-1:0]  w_s2_res;

    assign w_s2_load = r_s1_valid && (!r_out_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_in_fire = in_valid && in_ready;

    assign w_s1_amt = {{HI_W{1'b0}}, in_shamt[SPLIT-1:0]};
    assign w_s2_amt = {r_s1_shhi, {SPLIT{1'b0}}};

    assign w_s1_res = f_shift(in_data, w_s1_amt, in_op,
                              in_data[DATA_WIDTH-1]);
    assign w_s2_res = f_shift(r_s1_data, w_s2_amt, r_s1_op, r_s1_msb);

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_tag   = r_out_tag;

    // Stage 1: capture partially shifted operand and the remaining control.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_shhi  <= '0;
            r_s1_op    <= '0;
            r_s1_tag   <= '0;
            r_s1_msb   <= 1'b0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_in_fire) begin
            r_s1_valid <= 1'b1;
            r_s1_data  <= w_s1_res;
            r_s1_shhi  <= in_shamt[SHIFT_WIDTH-1:SPLIT];
            r_s1_op    <= in_op;
            r_s1_tag   <= in_tag;
            r_s1_msb   <= in_data[DATA_WIDTH-1];
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Stage 2: finish the shift and hold the result until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_tag   <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_s2_load) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_s2_res;
            r_out_tag   <= r_s1_tag;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule
